// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a word-organised SRAM: programmable wait states,
// byte-lane steering, two-cycle ERROR responses and write-to-read forwarding.
module ahb_lite_sram_slave #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned MEM_BYTES   = 4096,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA
);

    localparam int unsigned WORDS  = MEM_BYTES / 4;
    localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_write;

    logic [31:0]       r_mem [WORDS];

    logic              w_take;
    logic              w_illegal;
    logic              w_wr_en;
    logic [3:0]        w_be;
    logic [WIDX_W-1:0] w_wr_idx;
    logic [WIDX_W-1:0] w_rd_idx;
    logic              w_rd_read;
    logic [31:0]       w_rd_word;
    logic              w_hreadyout_nxt;
    logic              w_hresp_nxt;
    logic [31:0]       w_hrdata_nxt;
    logic              w_unused;

    // A new address phase is only sampled while this slave is not stalling the bus.
    assign w_take = HSEL & HREADY & HTRANS[1] &
                    ((r_state == S_IDLE) | (r_state == S_DATA) | (r_state == S_ERR2));

    assign w_illegal = (HSIZE > 3'd2) |
                       ((HSIZE == 3'd1) & HADDR[0]) |
                       ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00)) |
                       (32'(HADDR) >= 32'(MEM_BYTES));

    assign w_wr_en  = (r_state == S_DATA) & r_write;
    assign w_wr_idx = r_addr[WIDX_W+1:2];
    assign w_rd_idx = w_take ? HADDR[WIDX_W+1:2] : r_addr[WIDX_W+1:2];
    assign w_rd_read = w_take ? ~HWRITE : ~r_write;

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_addr[1:0];
            2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // State register; the bus outputs are registered from the next state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            HREADYOUT <= w_hreadyout_nxt;
            HRESP     <= w_hresp_nxt;
            HRDATA    <= w_hrdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_DATA;
            S_ERR1: w_state_nxt = S_ERR2;
            default: begin
                if (!w_take)        w_state_nxt = S_IDLE;
                else if (w_illegal) w_state_nxt = S_ERR1;
                else if (WAIT_STATES == 0) w_state_nxt = S_DATA;
                else                w_state_nxt = S_WAIT;
            end
        endcase
    end

    // Read data merges a write completing on the same edge to the same word.
    always_comb begin
        w_hreadyout_nxt = 1'b1;
        w_hresp_nxt     = 1'b0;
        w_hrdata_nxt    = 32'd0;
        w_rd_word       = r_mem[w_rd_idx];
        for (int k = 0; k < 4; k++) begin
            if (w_wr_en && (w_wr_idx == w_rd_idx) && w_be[k]) begin
                w_rd_word[8*k +: 8] = HWDATA[8*k +: 8];
            end
        end
        if ((w_state_nxt == S_WAIT) || (w_state_nxt == S_ERR1)) w_hreadyout_nxt = 1'b0;
        if ((w_state_nxt == S_ERR1) || (w_state_nxt == S_ERR2)) w_hresp_nxt = 1'b1;
        if ((w_state_nxt == S_DATA) && w_rd_read) w_hrdata_nxt = w_rd_word;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_size  <= 2'd0;
            r_write <= 1'b0;
        end else begin
            if (w_take) begin
                r_addr  <= HADDR;
                r_size  <= HSIZE[1:0];
                r_write <= HWRITE;
                r_cnt   <= 4'(WAIT_STATES - 1);
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge HCLK) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) r_mem[w_wr_idx][8*k +: 8] <= HWDATA[8*k +: 8];
            end
        end
    end

    assign w_unused = ^{HBURST, HPROT, HTRANS[0], r_addr, HADDR};

endmodule
